// File: rtl/dsp_mac_sequencer.sv
// Upstream control for a DSP48A1 slice: streams operand pairs into the slice, aligns
// OPMODE/CEP to the slice pipeline, and buffers each frame's sum of products.
module dsp_mac_sequencer #(
    parameter int TAPS = 8
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_cea,
    output logic        dsp_ceb,
    output logic        dsp_cem,
    output logic        dsp_cep,
    input  logic [47:0] dsp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        busy
);

    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        S_ACCUM,
        S_FLUSH,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_tap_cnt;
    logic [1:0]      r_flush_cnt;
    logic            r_vld1;
    logic            r_first1;
    logic            r_vld2;
    logic            r_first2;
    logic            r_out_valid;
    logic [47:0]     r_out_data;
    logic            w_accept;
    logic            w_last_tap;
    logic            w_flush_end;
    logic            w_buf_free;
    logic            w_capture;

    assign in_ready    = (r_state == S_ACCUM) && !RSTA;
    assign w_accept    = in_valid && in_ready;
    assign w_last_tap  = w_accept && (r_tap_cnt == CW'(TAPS - 1));
    assign w_flush_end = (r_state == S_FLUSH) && (r_flush_cnt == 2'd2);
    assign w_buf_free  = !r_out_valid || out_ready;

    assign dsp_a   = w_accept ? in_a : '0;
    assign dsp_b   = w_accept ? in_b : '0;
    assign dsp_cea = 1'b1;
    assign dsp_ceb = 1'b1;
    assign dsp_cem = 1'b1;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_ACCUM);

    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        dsp_opmode   = 8'h08;
        dsp_cep      = 1'b0;
        case (r_state)
            S_ACCUM: begin
                if (w_last_tap) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_end) begin
                    w_capture    = w_buf_free;
                    w_next_state = w_buf_free ? S_ACCUM : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_buf_free) begin
                    w_capture    = 1'b1;
                    w_next_state = S_ACCUM;
                end
            end
            default: w_next_state = S_ACCUM;
        endcase
        // Post-adder stage: first tap loads M alone so stale P is never summed in.
        if (r_vld2 && (r_state != S_WAIT)) begin
            dsp_opmode = r_first2 ? 8'h01 : 8'h09;
            dsp_cep    = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            r_tap_cnt   <= '0;
            r_flush_cnt <= '0;
            r_vld1      <= 1'b0;
            r_first1    <= 1'b0;
            r_vld2      <= 1'b0;
            r_first2    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tap_cnt <= w_last_tap ? '0 : r_tap_cnt + CW'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= w_flush_end ? 2'd0 : r_flush_cnt + 2'd1;
            end else begin
                r_flush_cnt <= '0;
            end
            r_vld1   <= w_accept;
            r_first1 <= w_accept && (r_tap_cnt == '0);
            r_vld2   <= r_vld1;
            r_first2 <= r_first1;
        end
    end

    // New capture takes priority over a simultaneous consumer pop.
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= dsp_p;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
